// File: rtl/bch_pkg.sv
// Shared constants and state type for the BCH decoder channel scheduler.
package bch_pkg;

   localparam int unsigned BCH_N     = 63;
   localparam int unsigned BCH_K     = 51;
   localparam int unsigned BIT_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } t_sched_state;

   // Index of the final beat of an n-beat phase, sized for the beat counter
   function automatic logic [BIT_CNT_W-1:0] last_beat(input int unsigned n);
      return BIT_CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, cyclically.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_ptr,
   output logic [CH_W-1:0]   o_grant,
   output logic              o_any_req
);

   int unsigned w_idx;
   logic        w_found;

   always_comb begin
      o_grant   = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      o_any_req = |i_req;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_idx = 32'(i_ptr) + i;
         if (w_idx >= NUM_CH) begin
            w_idx = w_idx - NUM_CH;
         end
         if (!w_found && i_req[CH_W'(w_idx)]) begin
            w_found = 1'b1;
            o_grant = CH_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/bch_scheduler.sv
// Time-shares one serial BCH(63,51) decoder across NUM_CH codeword channels.
// Optional per-channel completed-frame counters: define BCH_SCHED_STATS_EN.
module bch_scheduler
   import bch_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_valid,
   input  logic [NUM_CH-1:0] ch_data,
   output logic [NUM_CH-1:0] ch_ready,
   output logic              dec_in_valid,
   output logic              dec_in_data,
   input  logic              dec_in_ready,
   input  logic              dec_out_valid,
   input  logic              dec_out_data,
   output logic              dec_out_ready,
   output logic              out_valid,
   output logic              out_data,
   output logic              out_last,
   output logic [CH_W-1:0]   out_ch,
   input  logic              out_ready,
   output logic              busy
`ifdef BCH_SCHED_STATS_EN
   ,
   output logic [15:0]       frame_cnt [NUM_CH]
`endif
);

   localparam logic [BIT_CNT_W-1:0] N_LAST = last_beat(BCH_N);
   localparam logic [BIT_CNT_W-1:0] K_LAST = last_beat(BCH_K);

   t_sched_state           r_state;
   t_sched_state           w_next_state;
   logic [CH_W-1:0]        r_grant;
   logic [CH_W-1:0]        r_rr_ptr;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic [CH_W-1:0]        w_arb_grant;
   logic                   w_any_req;
   logic                   w_feed_beat;
   logic                   w_drain_beat;
   logic                   w_phase_end;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_arbiter (
      .i_req     (ch_valid),
      .i_ptr     (r_rr_ptr),
      .o_grant   (w_arb_grant),
      .o_any_req (w_any_req)
   );

   assign w_feed_beat  = (r_state == ST_FEED)  & ch_valid[r_grant] & dec_in_ready;
   assign w_drain_beat = (r_state == ST_DRAIN) & dec_out_valid & out_ready;
   assign w_phase_end  = (w_feed_beat & (r_bit_cnt == N_LAST)) |
                         (w_drain_beat & (r_bit_cnt == K_LAST));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_ARB;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_ARB:   if (w_any_req) w_next_state = ST_FEED;
         ST_FEED:  if (w_feed_beat && (r_bit_cnt == N_LAST)) w_next_state = ST_DRAIN;
         ST_DRAIN: if (w_drain_beat && (r_bit_cnt == K_LAST)) w_next_state = ST_ARB;
         default:  w_next_state = ST_ARB;
      endcase
   end

   // Only the granted channel is ever connected; everything else idles at 0.
   always_comb begin
      ch_ready      = '0;
      dec_in_valid  = 1'b0;
      dec_in_data   = 1'b0;
      dec_out_ready = 1'b0;
      out_valid     = 1'b0;
      out_data      = 1'b0;
      out_last      = 1'b0;
      case (r_state)
         ST_FEED: begin
            dec_in_valid      = ch_valid[r_grant];
            dec_in_data       = ch_data[r_grant];
            ch_ready[r_grant] = dec_in_ready;
         end
         ST_DRAIN: begin
            out_valid     = dec_out_valid;
            out_data      = dec_out_data;
            dec_out_ready = out_ready;
            out_last      = (r_bit_cnt == K_LAST) & dec_out_valid;
         end
         default: ;
      endcase
   end

   assign out_ch = r_grant;
   assign busy   = (r_state != ST_ARB);

   // Grant capture, round-robin pointer advance and beat counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_bit_cnt <= '0;
      end else begin
         if ((r_state == ST_ARB) && w_any_req) begin
            r_grant  <= w_arb_grant;
            r_rr_ptr <= (w_arb_grant == CH_W'(NUM_CH - 1)) ? '0 : w_arb_grant + CH_W'(1);
         end
         if (w_phase_end) begin
            r_bit_cnt <= '0;
         end else if (w_feed_beat || w_drain_beat) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
         end
      end
   end

`ifdef BCH_SCHED_STATS_EN
   logic [15:0] r_frame_cnt [NUM_CH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_frame_cnt[i] <= '0;
         end
      end else if (out_last && out_ready) begin
         r_frame_cnt[r_grant] <= r_frame_cnt[r_grant] + 16'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: doc/bch_scheduler.md
BCH_SCHEDULER -- requirements
Module: bch_scheduler

Interface
REQ-001 SHALL have parameter: NUM_CH, default 4, number of requesting serial codeword channels (2..8).
REQ-002 SHALL have parameter: CH_W, default $clog2(NUM_CH), channel-index width.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: ch_valid / ch_data / ch_ready  input / input / output  NUM_CH each  per-channel serial 63-bit codeword streams, MSB first.
REQ-006 SHALL have ports: dec_in_valid / dec_in_data  output  1 each, dec_in_ready  input  1  shared decoder input side.
REQ-007 SHALL have ports: dec_out_valid / dec_out_data  input  1 each, dec_out_ready  output  1  shared decoder output side, 51 corrected bits per codeword.
REQ-008 SHALL have ports: out_valid / out_data / out_last  output  1 each, out_ch  output  CH_W, out_ready  input  1  tagged decoded stream.
REQ-009 SHALL have port: busy  output  1  high in any state other than ST_ARB.

Function
REQ-010 SHALL implement states ST_ARB, ST_FEED, ST_DRAIN.
REQ-011 ST_ARB: if any ch_valid is high, SHALL register grant = first requesting channel at or after rr_ptr (cyclic), set rr_ptr = grant+1 mod NUM_CH, and enter ST_FEED next cycle; otherwise stay.
REQ-012 ST_FEED: dec_in_valid = ch_valid[grant]; dec_in_data = ch_data[grant]; ch_ready[grant] = dec_in_ready; all other ch_ready SHALL be 0.
REQ-013 A feed beat SHALL count only when dec_in_valid & dec_in_ready; after beat 63 (bit_cnt 62), SHALL enter ST_DRAIN and clear bit_cnt.
REQ-014 ch_valid[grant] dropping mid-frame SHALL stall without losing grant; other channels' requests SHALL be ignored until return to ST_ARB.
REQ-015 ST_DRAIN: out_valid = dec_out_valid; out_data = dec_out_data; dec_out_ready = out_ready; out_ch = grant; out_last = (bit_cnt == 50) & out_valid.
REQ-016 A drain beat SHALL count only when dec_out_valid & out_ready; after beat 51, SHALL return to ST_ARB.
REQ-017 Outside their active states, dec_in_valid, dec_out_ready, out_valid, out_last and all ch_ready SHALL be 0; out_ch SHALL hold grant.
REQ-018 Back-to-back frames SHALL incur exactly one ST_ARB bubble cycle between a frame's last drain beat and the next grant.
REQ-019 bit_cnt SHALL be 6 bits, compared against constants BCH_N-1 and BCH_K-1, and never wrap.
REQ-020 With all channels continuously valid, grants SHALL rotate 0,1,..,NUM_CH-1,0.

Reset
REQ-021 On rst low: state = ST_ARB, grant = 0, rr_ptr = 0, bit_cnt = 0, all outputs 0, asynchronously; a partial frame SHALL be discarded.
REQ-022 The decoder instance SHALL be reset in the same reset event; the system integrator SHALL guarantee this.

Configuration
REQ-023 Macro BCH_SCHED_STATS_EN defined: SHALL add output frame_cnt [NUM_CH][15:0], incremented for out_ch on each out_last handshake, wrapping 0xFFFF->0, reset to 0.
REQ-024 Without BCH_SCHED_STATS_EN: no frame_cnt port or registers SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package bch_pkg SHALL hold BCH_N=63, BCH_K=51 and the t_sched_state enum.
REQ-026 Round-robin selection SHALL be sub-module rr_arbiter (request vector, pointer in; grant index, any_req out, combinational).

Verification
REQ-027 Single channel 0: one zero-error codeword -> 51 out beats, out_ch=0, out_last only on beat 51, busy returns to 0.
REQ-028 Channels 0 and 2 valid simultaneously, rr_ptr=0 -> frame order ch0, ch2, ch0; exactly one bubble between frames.
REQ-029 Channel 1 valid deasserted for 10 cycles at bit 30 -> grant held, 63 bits delivered intact, no other ch_ready asserted.
REQ-030 out_ready toggling 50% random -> all 51 decoded bits correct and in order; dec_out_ready mirrors out_ready.
REQ-031 rst pulsed low at feed bit 40 -> outputs 0 immediately; the next frame starts cleanly at bit 0 from channel 0.
REQ-032 With BCH_SCHED_STATS_EN: 3 frames on ch3 -> frame_cnt[3]=3, other counts 0.
